// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the TPU controller instruction path:
// field layout, func/opcode codes, region nibbles and the instruction word.
package tpu_isa_pkg;

    localparam int INSTR_W = 28;

    localparam int FUNC_LSB = 24;
    localparam int OPC_LSB  = 20;
    localparam int RS1_LSB  = 10;
    localparam int RS2_LSB  = 0;

    localparam logic [7:0] LOAD_IN = 8'h12;
    localparam logic [7:0] LOAD_W  = 8'h22;
    localparam logic [7:0] MOVE    = 8'h11;
    localparam logic [7:0] COMP    = 8'h14;
    localparam logic [7:0] HALT    = 8'hFF;

    localparam logic [3:0] REG_SHM   = 4'b0001;
    localparam logic [3:0] REG_INBUF = 4'b0010;
    localparam logic [3:0] REG_WBUF  = 4'b0100;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] opcode;
        logic [9:0] rs1;
        logic [9:0] rs2;
    } instr_t;

    localparam instr_t HALT_WORD = '{
        func:   HALT[7:4],
        opcode: HALT[3:0],
        rs1:    10'd0,
        rs2:    10'd0
    };

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_ARMED
    } state_t;

    function automatic logic is_legal(input logic [7:0] fo);
        return fo inside {LOAD_IN, LOAD_W, MOVE, COMP, HALT};
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction buffer: one write port, one registered read port.
// The read register holds its value when no read is requested.
module instr_mem #(
    parameter int DEPTH = 256,
    parameter int W     = 28,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction buffer, fetch and decode for the TPU controller.
// Optional INSTR_PARITY_EN: per-entry even parity with sticky parity_err.
module instr_fetch_decode
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = INSTR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_wr_valid,
    input  logic [IW-1:0] prog_wr_data,
    output logic          prog_wr_ready,
    input  logic          prog_clear,
    input  logic          prog_commit,
    output logic          prog_armed,
    output logic [8:0]    prog_len,
    input  logic          insbuf_en,
    input  logic [7:0]    pc,
    input  logic          decoder_en,
    output logic [3:0]    func,
    output logic [3:0]    opcode,
    output logic [9:0]    rs1,
    output logic [9:0]    rs2,
`ifdef INSTR_PARITY_EN
    output logic          parity_err,
`endif
    output logic          illegal_instr,
    output logic          pc_overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_PARITY_EN
    localparam int MW = IW + 1;
`else
    localparam int MW = IW;
`endif

    state_t        state_q;
    logic [8:0]    prog_len_q;
    logic          halt_q;
    logic          ovr_q;
    logic          ill_q;
    instr_t        dec_q;
    instr_t        ir;
    logic [MW-1:0] wdata;
    logic [MW-1:0] rdata;
    logic          wr_acc;
    logic          fetch_ok;
    logic          par_bad;

    assign prog_wr_ready = (state_q != ST_ARMED) && (prog_len_q < 9'(DEPTH));
    assign wr_acc        = prog_wr_valid && prog_wr_ready && !prog_clear;
    assign fetch_ok      = (state_q == ST_ARMED) && ({1'b0, pc} < prog_len_q);

`ifdef INSTR_PARITY_EN
    logic fetch_q;
    logic perr_q;

    assign wdata   = {^prog_wr_data, prog_wr_data};
    assign par_bad = ^rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            fetch_q <= insbuf_en;
            if (prog_clear) begin
                perr_q <= 1'b0;
            end else if (fetch_q && !halt_q && par_bad) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign parity_err = perr_q;
`else
    assign wdata   = prog_wr_data;
    assign par_bad = 1'b0;
`endif

    instr_mem #(
        .DEPTH (DEPTH),
        .W     (MW),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (wr_acc),
        .waddr_i (prog_len_q[AW-1:0]),
        .wdata_i (wdata),
        .re_i    (insbuf_en),
        .raddr_i (pc[AW-1:0]),
        .rdata_o (rdata)
    );

    // ir is the RAM read register, overridden by HALT for out-of-program fetches
    always_comb begin
        ir = instr_t'(rdata[IW-1:0]);
        if (halt_q || par_bad) begin
            ir = HALT_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            prog_len_q <= 9'd0;
            halt_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ill_q      <= 1'b0;
            dec_q      <= '0;
        end else begin
            if (prog_clear) begin
                state_q    <= ST_EMPTY;
                prog_len_q <= 9'd0;
                ovr_q      <= 1'b0;
                ill_q      <= 1'b0;
            end else begin
                if (wr_acc) begin
                    prog_len_q <= prog_len_q + 9'd1;
                    if (state_q == ST_EMPTY) begin
                        state_q <= ST_LOAD;
                    end
                end
                if (prog_commit && state_q != ST_ARMED) begin
                    state_q <= ST_ARMED;
                end
                if (insbuf_en && state_q == ST_ARMED && !fetch_ok) begin
                    ovr_q <= 1'b1;
                end
                if (decoder_en && !is_legal({ir.func, ir.opcode})) begin
                    ill_q <= 1'b1;
                end
            end
            if (insbuf_en) begin
                halt_q <= !fetch_ok;
            end
            if (decoder_en) begin
                dec_q <= ir;
            end
        end
    end

    assign prog_armed    = (state_q == ST_ARMED);
    assign prog_len      = prog_len_q;
    assign func          = dec_q.func;
    assign opcode        = dec_q.opcode;
    assign rs1           = dec_q.rs1;
    assign rs2           = dec_q.rs2;
    assign illegal_instr = ill_q;
    assign pc_overrun    = ovr_q;

endmodule
